sram_access_sequencer: RTL and testbench
========================================

Name: sram_access_sequencer

Overview:
Sequences one decode pass (UART load -> IDCT stage M2 -> colourspace stage M1 -> display) and owns the single SRAM controller port, muxing address/write-data/we_n among UART, IDCT, CSC and VGA clients by state. It issues one-cycle stage start pulses, waits for finish handshakes, inserts a bus-idle gap between stages, and traps hung stages with a watchdog. It sits in the top level between the client units and the SRAM controller.

Parameters:
TIMEOUT_CYCLES, 50000000, max cycles in any WAIT state before error (50000000 = 1 s at 50 MHz)
WD_WIDTH, 26, watchdog counter width; must hold TIMEOUT_CYCLES-1
GAP_CYCLES, 2, idle SRAM cycles between M2 finish and M1 start; must be >=1

Ports:
CLOCK_50_I  in  1  50 MHz clock
resetn  in  1  asynchronous, active-low reset
uart_start  in  1  pulse: UART start bit detected
uart_done  in  1  pulse: UART 1 s timeout, file received
M2_finish  in  1  IDCT stage finished (level or pulse)
M1_finish  in  1  CSC stage finished (level or pulse)
uart_addr/uart_wdata/uart_we_n  in  18/16/1  UART client bus
idct_addr/idct_wdata/idct_we_n  in  18/16/1  IDCT client bus
csc_addr/csc_wdata/csc_we_n  in  18/16/1  CSC client bus
vga_addr  in  18  VGA read address
SRAM_address  out  18  to SRAM controller
SRAM_write_data  out  16  to SRAM controller
SRAM_we_n  out  1  to SRAM controller
M2_start  out  1  registered one-cycle start to IDCT
M1_start  out  1  registered one-cycle start to CSC
VGA_enable  out  1  registered VGA enable
done  out  1  registered one-cycle pass-complete pulse
timeout_err  out  1  sticky watchdog error
state_o  out  4  current state encoding (debug/LEDs)

Behaviour:
- Reset: state S_IDLE, M2_start=M1_start=done=timeout_err=0, VGA_enable=1, watchdog=0, gap counter=0.
- States and SRAM owner (mux is combinational from registered state, zero latency):
  S_IDLE (0, VGA: addr=vga_addr, wdata=0, we_n=1); uart_start -> S_UART, VGA_enable<=0.
  S_UART (1, UART); uart_done -> S_M2_START.
  S_M2_START (2, IDCT); M2_start=1 this cycle only; watchdog<=0; -> S_M2_WAIT.
  S_M2_WAIT (3, IDCT); M2_finish -> S_GAP (gap counter<=0); else watchdog++, if watchdog==TIMEOUT_CYCLES-1 -> S_ERR.
  S_GAP (4, none: addr=0, wdata=0, we_n=1); counts GAP_CYCLES cycles then -> S_M1_START.
  S_M1_START (5, CSC); M1_start=1 one cycle; watchdog<=0; -> S_M1_WAIT.
  S_M1_WAIT (6, CSC); M1_finish -> S_DONE; watchdog rule as S_M2_WAIT.
  S_DONE (7, VGA); done=1 one cycle; VGA_enable<=1; -> S_IDLE.
  S_ERR (8, VGA); timeout_err<=1, VGA_enable<=1; uart_start -> clears timeout_err, VGA_enable<=0, -> S_UART.
- Finish inputs are sampled only in WAIT states; finish high during START, GAP or other states is ignored (no skip).
- Finish and watchdog expiry in the same cycle: finish wins.
- uart_start ignored outside S_IDLE/S_ERR; uart_done ignored outside S_UART.
- Unused encodings 9-15 -> S_IDLE next cycle, SRAM idle (we_n=1).
- Reset asserted mid-pass: immediate return to reset values; no start pulse emitted on release.
- SRAM_we_n never 0 in S_IDLE, S_GAP, S_DONE, S_ERR regardless of client inputs.

Test Plan:
- Normal pass (TIMEOUT_CYCLES=100, GAP_CYCLES=2): uart_start, uart_done, M2_finish 20 cycles after M2_start, M1_finish 30 after M1_start -> state sequence 0,1,2,3..,4,4,5,6..,7,0; exactly one M2_start and one M1_start pulse; M1_start exactly 3 cycles after M2_finish sampled; done one cycle; VGA_enable 0 from S_UART through S_M1_WAIT.
- Ownership: idct_we_n=0, idct_addr=18'h1234 during S_M2_WAIT -> SRAM_address=18'h1234, we_n=0; same inputs in S_GAP -> we_n=1, addr=0.
- Watchdog (TIMEOUT_CYCLES=100): no M2_finish -> S_ERR after 100 cycles in S_M2_WAIT, timeout_err=1, VGA_enable=1; later uart_start -> timeout_err=0, state 1.
- Boundary: M2_finish on cycle 100 of S_M2_WAIT (expiry cycle) -> S_GAP, timeout_err stays 0.
- Spurious: M1_finish held high from before M1_start -> M1_start still pulses; S_M1_WAIT exits next cycle; uart_start in S_M2_WAIT -> ignored.
- Reset mid S_M1_WAIT -> all outputs to reset values same cycle, state_o=0, no further start pulses.

Source files
------------

// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer
// Sequences one decode pass (UART load -> IDCT M2 -> CSC M1 -> display) and
// owns the single SRAM controller port, granting it to one client per state.
// Stage starts are one-cycle registered pulses; each WAIT state is guarded
// by a watchdog that traps a hung stage in S_ERR.
module sram_access_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned WD_WIDTH       = 26,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        uart_start,
  input  logic        uart_done,
  input  logic        M2_finish,
  input  logic        M1_finish,
  input  logic [17:0] uart_addr,
  input  logic [15:0] uart_wdata,
  input  logic        uart_we_n,
  input  logic [17:0] idct_addr,
  input  logic [15:0] idct_wdata,
  input  logic        idct_we_n,
  input  logic [17:0] csc_addr,
  input  logic [15:0] csc_wdata,
  input  logic        csc_we_n,
  input  logic [17:0] vga_addr,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        M2_start,
  output logic        M1_start,
  output logic        VGA_enable,
  output logic        done,
  output logic        timeout_err,
  output logic [3:0]  state_o
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_UART     = 4'd1;
  localparam logic [3:0] S_M2_START = 4'd2;
  localparam logic [3:0] S_M2_WAIT  = 4'd3;
  localparam logic [3:0] S_GAP      = 4'd4;
  localparam logic [3:0] S_M1_START = 4'd5;
  localparam logic [3:0] S_M1_WAIT  = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_ERR      = 4'd8;

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WD_WIDTH-1:0] WD_LAST  = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [3:0]          state_q, state_d;
  logic [WD_WIDTH-1:0] wd_q, wd_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                m2_start_q, m2_start_d;
  logic                m1_start_q, m1_start_d;
  logic                vga_en_q, vga_en_d;
  logic                done_q, done_d;
  logic                terr_q, terr_d;

  // Next-state, watchdog, gap counter and sticky error decode.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    terr_d  = terr_q;

    case (state_q)
      S_IDLE: begin
        if (uart_start) state_d = S_UART;
      end
      S_UART: begin
        if (uart_done) state_d = S_M2_START;
      end
      S_M2_START: begin
        wd_d    = '0;
        state_d = S_M2_WAIT;
      end
      S_M2_WAIT: begin
        // Finish is checked first so it wins over a same-cycle expiry.
        if (M2_finish) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else if (wd_q == WD_LAST) begin
          terr_d  = 1'b1;
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + WD_WIDTH'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_M1_START;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_M1_START: begin
        wd_d    = '0;
        state_d = S_M1_WAIT;
      end
      S_M1_WAIT: begin
        if (M1_finish) begin
          state_d = S_DONE;
        end else if (wd_q == WD_LAST) begin
          terr_d  = 1'b1;
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + WD_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (uart_start) begin
          terr_d  = 1'b0;
          state_d = S_UART;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered strobes decoded from the next state, so each is high exactly
  // while the FSM sits in the state that owns it.
  always_comb begin
    m2_start_d = (state_d == S_M2_START);
    m1_start_d = (state_d == S_M1_START);
    done_d     = (state_d == S_DONE);
    case (state_d)
      S_UART, S_M2_START, S_M2_WAIT, S_GAP, S_M1_START, S_M1_WAIT: vga_en_d = 1'b0;
      default:                                                      vga_en_d = 1'b1;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wd_q       <= '0;
      gap_q      <= '0;
      m2_start_q <= 1'b0;
      m1_start_q <= 1'b0;
      vga_en_q   <= 1'b1;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      m2_start_q <= m2_start_d;
      m1_start_q <= m1_start_d;
      vga_en_q   <= vga_en_d;
      done_q     <= done_d;
      terr_q     <= terr_d;
    end
  end

  // SRAM port mux: combinational from the registered state, zero latency.
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        SRAM_address = vga_addr;
      end
      S_UART: begin
        SRAM_address    = uart_addr;
        SRAM_write_data = uart_wdata;
        SRAM_we_n       = uart_we_n;
      end
      S_M2_START, S_M2_WAIT: begin
        SRAM_address    = idct_addr;
        SRAM_write_data = idct_wdata;
        SRAM_we_n       = idct_we_n;
      end
      S_M1_START, S_M1_WAIT: begin
        SRAM_address    = csc_addr;
        SRAM_write_data = csc_wdata;
        SRAM_we_n       = csc_we_n;
      end
      default: begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

  assign M2_start    = m2_start_q;
  assign M1_start    = m1_start_q;
  assign VGA_enable  = vga_en_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Testbench for sram_access_sequencer: directed pass scenarios with
// randomized client buses and randomized don't-care control inputs.
// Expected state per cycle comes from a pass-level timeline model.
module tb_sram_access_sequencer;

  localparam int TO  = 100;
  localparam int GAP = 2;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn     = 1'b0;
  logic        uart_start = 1'b0;
  logic        uart_done  = 1'b0;
  logic        M2_finish  = 1'b0;
  logic        M1_finish  = 1'b0;
  logic [17:0] uart_addr  = '0;
  logic [15:0] uart_wdata = '0;
  logic        uart_we_n  = 1'b1;
  logic [17:0] idct_addr  = '0;
  logic [15:0] idct_wdata = '0;
  logic        idct_we_n  = 1'b1;
  logic [17:0] csc_addr   = '0;
  logic [15:0] csc_wdata  = '0;
  logic        csc_we_n   = 1'b1;
  logic [17:0] vga_addr   = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        M2_start;
  logic        M1_start;
  logic        VGA_enable;
  logic        done;
  logic        timeout_err;
  logic [3:0]  state_o;

  int tests = 0;
  int fails = 0;
  bit hold_bus = 1'b0;
  bit m1_hold  = 1'b0;

  sram_access_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .WD_WIDTH(7),
    .GAP_CYCLES(GAP)
  ) dut (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn(resetn),
    .uart_start(uart_start),
    .uart_done(uart_done),
    .M2_finish(M2_finish),
    .M1_finish(M1_finish),
    .uart_addr(uart_addr),
    .uart_wdata(uart_wdata),
    .uart_we_n(uart_we_n),
    .idct_addr(idct_addr),
    .idct_wdata(idct_wdata),
    .idct_we_n(idct_we_n),
    .csc_addr(csc_addr),
    .csc_wdata(csc_wdata),
    .csc_we_n(csc_we_n),
    .vga_addr(vga_addr),
    .SRAM_address(SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n),
    .M2_start(M2_start),
    .M1_start(M1_start),
    .VGA_enable(VGA_enable),
    .done(done),
    .timeout_err(timeout_err),
    .state_o(state_o)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs that the given state must ignore get random values.
  task automatic noise(input logic [3:0] st);
    if (!(st == 4'd0 || st == 4'd8)) uart_start = 1'($urandom);
    if (st != 4'd1) uart_done = 1'($urandom);
    if (st != 4'd3) M2_finish = 1'($urandom);
    if (st != 4'd6) M1_finish = m1_hold ? 1'b1 : 1'($urandom);
    if (!hold_bus) begin
      uart_addr  = 18'($urandom); uart_wdata = 16'($urandom); uart_we_n = 1'($urandom);
      idct_addr  = 18'($urandom); idct_wdata = 16'($urandom); idct_we_n = 1'($urandom);
      csc_addr   = 18'($urandom); csc_wdata  = 16'($urandom); csc_we_n  = 1'($urandom);
      vga_addr   = 18'($urandom);
    end
  endtask

  task automatic check_outputs(input logic [3:0] st, input bit terr);
    logic [17:0] ea;
    logic [15:0] ew;
    logic        ewe;
    case (st)
      4'd1:       begin ea = uart_addr; ew = uart_wdata; ewe = uart_we_n; end
      4'd2, 4'd3: begin ea = idct_addr; ew = idct_wdata; ewe = idct_we_n; end
      4'd5, 4'd6: begin ea = csc_addr;  ew = csc_wdata;  ewe = csc_we_n;  end
      4'd4:       begin ea = '0;        ew = '0;         ewe = 1'b1;      end
      default:    begin ea = vga_addr;  ew = '0;         ewe = 1'b1;      end
    endcase
    chk("state_o", 32'(state_o), 32'(st));
    chk("sram_addr", 32'(SRAM_address), 32'(ea));
    chk("sram_wdata", 32'(SRAM_write_data), 32'(ew));
    chk("sram_we_n", 32'(SRAM_we_n), 32'(ewe));
    chk("m2_start", 32'(M2_start), 32'(st == 4'd2));
    chk("m1_start", 32'(M1_start), 32'(st == 4'd5));
    chk("done", 32'(done), 32'(st == 4'd7));
    chk("timeout_err", 32'(timeout_err), 32'(terr));
    if (st != 4'd7) chk("vga_enable", 32'(VGA_enable), 32'(st == 4'd0 || st == 4'd8));
  endtask

  // Called at a falling edge; checks the current cycle then advances one cycle.
  task automatic step(input logic [3:0] st, input bit terr);
    noise(st);
    #1;
    check_outputs(st, terr);
    @(posedge CLOCK_50_I);
    @(negedge CLOCK_50_I);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    check_outputs(4'd0, 1'b0);
    @(negedge CLOCK_50_I);
    uart_start = 1'b0;
    step(4'd0, 1'b0);
    step(4'd0, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uart_start = 1'b0;
      step(4'd0, 1'b0);
    end
  endtask

  // One pass: u UART cycles, M2/M1 finish on wait cycle l2/l1 (beyond TO
  // means never, so the watchdog traps). rst_m1 >= 0 resets on that M1 wait cycle.
  task automatic run_pass(input int u, input int l2, input int l1, input bit from_err, input int rst_m1);
    uart_start = 1'b1;
    step(from_err ? 4'd8 : 4'd0, from_err);
    for (int i = 0; i < u; i++) begin
      uart_done = (i == u - 1);
      step(4'd1, 1'b0);
    end
    step(4'd2, 1'b0);
    for (int i = 0; i < l2 && i < TO; i++) begin
      M2_finish = (i == l2 - 1);
      step(4'd3, 1'b0);
    end
    if (l2 > TO) begin
      uart_start = 1'b0; step(4'd8, 1'b1);
      uart_start = 1'b0; step(4'd8, 1'b1);
      return;
    end
    for (int i = 0; i < GAP; i++) step(4'd4, 1'b0);
    step(4'd5, 1'b0);
    for (int i = 0; i < l1 && i < TO; i++) begin
      if (i == rst_m1) begin
        do_reset();
        return;
      end
      M1_finish = (i == l1 - 1);
      step(4'd6, 1'b0);
    end
    if (l1 > TO) begin
      uart_start = 1'b0; step(4'd8, 1'b1);
      uart_start = 1'b0; step(4'd8, 1'b1);
      return;
    end
    step(4'd7, 1'b0);
  endtask

  initial begin
    int u, l2, l1;
    @(negedge CLOCK_50_I);
    uart_start = 1'b0;
    step(4'd0, 1'b0);
    step(4'd0, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      uart_start = 1'b0;
      step(4'd0, 1'b0);
    end

    // normal pass
    run_pass(2, 20, 30, 1'b0, -1);

    // fixed client buses: IDCT writing 0x1234 must not leak into the gap
    hold_bus   = 1'b1;
    idct_addr  = 18'h1234; idct_wdata = 16'hBEEF; idct_we_n = 1'b0;
    uart_addr  = 18'h0AAAA; uart_wdata = 16'h1111; uart_we_n = 1'b0;
    csc_addr   = 18'h05555; csc_wdata  = 16'h2222; csc_we_n  = 1'b0;
    vga_addr   = 18'h00321;
    uart_start = 1'b0;
    step(4'd0, 1'b0);
    run_pass(1, 5, 5, 1'b0, -1);
    hold_bus = 1'b0;

    // randomized pass lengths
    for (int k = 0; k < 4; k++) begin
      u  = int'($urandom_range(4, 1));
      l2 = int'($urandom_range(99, 1));
      l1 = int'($urandom_range(99, 1));
      run_pass(u, l2, l1, 1'b0, -1);
      uart_start = 1'b0;
      step(4'd0, 1'b0);
    end

    // M2 watchdog, then recovery with M2 finishing on the expiry cycle
    run_pass(2, TO + 50, 1, 1'b0, -1);
    run_pass(1, TO, 3, 1'b1, -1);
    uart_start = 1'b0;
    step(4'd0, 1'b0);

    // M1 watchdog, then recovery with M1 finishing on the expiry cycle
    run_pass(1, 4, TO + 20, 1'b0, -1);
    run_pass(1, 6, TO, 1'b1, -1);

    // M1_finish held high from before M1_start
    m1_hold = 1'b1;
    run_pass(1, 8, 1, 1'b0, -1);
    m1_hold = 1'b0;

    // reset in the middle of S_M1_WAIT
    run_pass(2, 10, 50, 1'b0, 12);

    // normal pass after reset recovery
    run_pass(1, 3, 4, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
